// File: rtl/decodificador_servo_3.sv
// decodificador_servo_3
//   Servo-side receiver for the 3-bit servo PWM link. It measures each high pulse
//   of the 50 Hz control waveform in clock cycles and quantises it to the nearest
//   of 8 positions (0.7 ms + k*1.5 ms/7). It also flags a missing signal.
//
// Ports
//   clock      in   1       system clock (50 MHz nominal)
//   reset      in   1       asynchronous, active-low
//   pwm        in   1       servo waveform, asynchronous to clock
//   posicao    out  3       last successfully decoded position
//   pronto     out  1       one-cycle pulse per completed measurement (valid or not)
//   valido     out  1       last measurement was in range
//   erro       out  1       last measurement was out of range
//   sem_sinal  out  1       no rising edge for TIMEOUT cycles
//   largura    out  W_LARG  raw width of the last completed pulse, in cycles
//   db_estado  out  2       current FSM state
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ESPERA 00  | idle, waiting for a low->high edge on the synchronised input
// MEDE   01  | counting high cycles until the falling edge
// DECODIFICA | one cycle: classify largura, update outputs, pulse pronto
//        10  |
module decodificador_servo_3 #(
  parameter int LARG_MIN = 35000,
  parameter int PASSO    = 10714,
  parameter int TIMEOUT  = 1200000,
  parameter int W_LARG   = 17,
  parameter int W_TO     = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pwm,
  output logic [2:0]        posicao,
  output logic              pronto,
  output logic              valido,
  output logic              erro,
  output logic              sem_sinal,
  output logic [W_LARG-1:0] largura,
  output logic [1:0]        db_estado
);

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    MEDE       = 2'b01,
    DECODIFICA = 2'b10
  } estado_t;

  localparam int WE      = W_LARG + 1;
  localparam int LIM_INF = LARG_MIN - PASSO / 2;
  localparam int LIM_SUP = LARG_MIN + 7 * PASSO + PASSO / 2;

  localparam logic [W_TO-1:0] TO_MAX = W_TO'(TIMEOUT);
  localparam logic [W_TO-1:0] TO_M1  = W_TO'(TIMEOUT - 1);

  estado_t           estado;
  logic              sync1, s, s_ant;
  logic [1:0]        vld;
  logic              armado;
  logic [W_LARG-1:0] cnt;
  logic [W_TO-1:0]   cnt_to;

  logic              sobe, desce, to_reach;
  logic [WE-1:0]     larg_ext;
  logic [2:0]        pos_calc;
  logic              faixa_ok;

  // armado stays low until a low level has been seen on a fully primed
  // synchroniser, so a pulse already high at reset release is not measured.
  assign sobe     = s & ~s_ant & armado;
  assign desce    = ~s & s_ant;
  assign to_reach = ~sobe & (cnt_to == TO_M1);

  assign larg_ext = {1'b0, largura};

  always_comb begin
    pos_calc = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      if (larg_ext >= WE'(LIM_INF + k * PASSO)) pos_calc = pos_calc + 3'd1;
    end
  end

  // A saturated count means the real width is unknown, so it is never valid.
  assign faixa_ok = ~(&largura) &&
                    (larg_ext >= WE'(LIM_INF)) &&
                    (larg_ext <  WE'(LIM_SUP));

  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= ESPERA;
      sync1     <= 1'b0;
      s         <= 1'b0;
      s_ant     <= 1'b0;
      vld       <= 2'b00;
      armado    <= 1'b0;
      cnt       <= '0;
      cnt_to    <= '0;
      posicao   <= 3'd0;
      pronto    <= 1'b0;
      valido    <= 1'b0;
      erro      <= 1'b0;
      sem_sinal <= 1'b0;
      largura   <= '0;
    end else begin
      sync1  <= pwm;
      s      <= sync1;
      s_ant  <= s;
      vld    <= {vld[0], 1'b1};
      if (vld[1] && !s) armado <= 1'b1;

      pronto <= 1'b0;

      if (sobe) begin
        cnt_to    <= '0;
        sem_sinal <= 1'b0;
      end else if (cnt_to != TO_MAX) begin
        cnt_to <= cnt_to + W_TO'(1);
      end

      // Timeout beats a coincident falling edge: measurement dropped, no pronto.
      if (to_reach) begin
        sem_sinal <= 1'b1;
        valido    <= 1'b0;
        estado    <= ESPERA;
      end else begin
        case (estado)
          ESPERA: begin
            if (sobe) begin
              cnt    <= W_LARG'(1);
              estado <= MEDE;
            end
          end
          MEDE: begin
            if (desce) begin
              largura <= cnt;
              estado  <= DECODIFICA;
            end else if (s && !(&cnt)) begin
              cnt <= cnt + W_LARG'(1);
            end
          end
          DECODIFICA: begin
            pronto <= 1'b1;
            estado <= ESPERA;
            if (faixa_ok) begin
              posicao <= pos_calc;
              valido  <= 1'b1;
              erro    <= 1'b0;
            end else begin
              valido  <= 1'b0;
              erro    <= 1'b1;
            end
          end
          default: estado <= ESPERA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decodificador_servo_3.sv
module tb_decodificador_servo_3;
  // Scaled-down timing so the whole run stays short; thresholds follow the same rules.
  localparam int LM  = 350;
  localparam int PS  = 100;
  localparam int TO  = 6000;
  localparam int WL  = 11;
  localparam int WT  = 13;
  localparam int SAT = (1 << WL) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pwm   = 1'b0;
  logic [2:0]    posicao;
  logic          pronto, valido, erro, sem_sinal;
  logic [WL-1:0] largura;
  logic [1:0]    db_estado;

  decodificador_servo_3 #(
    .LARG_MIN(LM), .PASSO(PS), .TIMEOUT(TO), .W_LARG(WL), .W_TO(WT)
  ) dut (
    .clock(clock), .reset(reset), .pwm(pwm),
    .posicao(posicao), .pronto(pronto), .valido(valido), .erro(erro),
    .sem_sinal(sem_sinal), .largura(largura), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int pos;
    bit val;
    int larg;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_pos = 0;
  int   last_larg = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: nearest position from the nominal 0.7 ms + k*step rule.
  function automatic void ref_decode(input int w, output bit v, output int p);
    int lo, hi;
    lo = LM - PS / 2;
    hi = LM + 7 * PS + PS / 2;
    v  = (w >= lo) && (w < hi) && (w < SAT);
    p  = v ? (w - lo) / PS : 0;
    if (p > 7) p = 7;
  endfunction

  task automatic pulse(input int high, input int low, input bit expect_out);
    int  w, p;
    bit  v;
    exp_t e;
    @(negedge clock) pwm = 1'b1;
    repeat (high) @(negedge clock);
    pwm = 1'b0;
    if (expect_out) begin
      w = (high > SAT) ? SAT : high;
      ref_decode(w, v, p);
      if (v) last_pos = p;
      last_larg = w;
      e.pos  = last_pos;
      e.val  = v;
      e.larg = w;
      e.due  = cyc + 4;
      q.push_back(e);
    end
    repeat (low) @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock);
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor: every pronto must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && pronto) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pronto: got pronto=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("latency_cycle", cyc, e.due);
        chk("posicao", int'(posicao), e.pos);
        chk("valido", int'(valido), int'(e.val));
        chk("erro", int'(erro), int'(!e.val));
        chk("largura", int'(largura), e.larg);
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clock);
    $display("FAIL watchdog: got no completion expected finish before 200000 cycles");
    $fatal(1);
  end

  int t3_w[8] = '{399, 400, 999, 1000, 1099, 1100, 299, 300};

  initial begin
    // T1: reset with pwm high; the already-high pulse is ignored
    pwm   = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_posicao", int'(posicao), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_sem_sinal", int'(sem_sinal), 0);
    chk("rst_largura", int'(largura), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    chk("t1_estado_ignored", int'(db_estado), 0);
    pwm = 1'b0;
    repeat (100) @(negedge clock);
    chk("t1_largura_untouched", int'(largura), 0);

    // T2: nominal frames
    pulse(350, 300, 1);
    pulse(550, 300, 1);
    pulse(1050, 300, 1);

    // T3: threshold edges and range limits
    foreach (t3_w[i]) pulse(t3_w[i], 200, 1);

    // T4: out-of-range pulse holds posicao
    pulse(650, 200, 1);
    pulse(200, 200, 1);
    pulse(350, 200, 1);

    // saturated counter is invalid
    pulse(2100, 200, 1);

    // randomized widths across and beyond the valid window
    for (int i = 0; i < 14; i++)
      pulse($urandom_range(150, 1250), $urandom_range(50, 400), 1);
    drain();

    // T5: input held low past the timeout
    repeat (TO + 20) @(negedge clock);
    chk("t5_sem_sinal_set", int'(sem_sinal), 1);
    chk("t5_valido_cleared", int'(valido), 0);
    pulse(750, 100, 1);
    chk("t5_sem_sinal_cleared", int'(sem_sinal), 0);
    drain();

    // T6: input stuck high past the timeout
    @(negedge clock) pwm = 1'b1;
    repeat (TO + 500) @(negedge clock);
    chk("t6_sem_sinal_set", int'(sem_sinal), 1);
    chk("t6_estado_espera", int'(db_estado), 0);
    chk("t6_valido_cleared", int'(valido), 0);
    chk("t6_largura_kept", int'(largura), last_larg);
    pwm = 1'b0;
    repeat (50) @(negedge clock);
    chk("t6_largura_after_fall", int'(largura), last_larg);
    chk("t6_posicao_kept", int'(posicao), last_pos);

    // recovery
    pulse(850, 100, 1);
    chk("recover_sem_sinal", int'(sem_sinal), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
